// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops bytes from the rx FIFO, parses SOF/LEN/payload/CHK frames, releases good payloads.
// Latency: first payload byte is valid one cycle after the CHK byte is popped, then one byte per cycle.
// Backpressure: out_ready low holds the output stable; no pops happen during release, so the rx FIFO absorbs it.
// Optional: define FRAME_TIMEOUT_EN to drop a frame after TIMEOUT_CYC cycles without a byte (err_code 11).
module uart_frame_parser #(
  parameter int              DBIT        = 8,
  parameter int              MAX_LEN     = 16,
  parameter logic [DBIT-1:0] SOF         = 8'hA5,
  parameter int              TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] rx_data,
  output logic            rx_rd,
  output logic [DBIT-1:0] out_data,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic            frame_ok,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic            busy
);

  // len/idx hold 0..MAX_LEN; the buffer address only needs to cover 0..MAX_LEN-1
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   len, len_nx;
  logic [LW-1:0]   idx, idx_nx;
  logic [DBIT-1:0] chk, chk_nx;
  logic            frame_ok_nx, frame_err_nx;
  logic [1:0]      err_code_nx;
  logic            buf_we;
  logic            timeout;
  logic            len_good;
  logic            at_last;
  logic [DBIT-1:0] buf_mem [MAX_LEN];

  // A byte is consumed whenever one is offered outside payload release; nothing is popped in reset
  assign rx_rd = reset && !rx_empty && (state != S_OUT);

  assign len_good = (rx_data != '0) && (rx_data <= DBIT'(MAX_LEN));
  assign at_last  = (idx == len - LW'(1));

  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);
  assign out_last  = out_valid && at_last;
  assign out_data  = buf_mem[idx[AW-1:0]];

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tcnt;
  logic          counting;

  assign counting = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign timeout  = counting && !rx_rd && (tcnt == TW'(TIMEOUT_CYC - 1));

  // Idle-cycle counter; every entry into a counted state coincides with a pop, so clearing on pop covers entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (!counting || rx_rd) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end
`else
  // No counter: a stalled frame waits forever (TIMEOUT_CYC has no effect in this build)
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // State, frame bookkeeping and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      chk       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= state_nx;
      len       <= len_nx;
      idx       <= idx_nx;
      chk       <= chk_nx;
      frame_ok  <= frame_ok_nx;
      frame_err <= frame_err_nx;
      err_code  <= err_code_nx;
    end
  end

  // Payload buffer; contents are only meaningful between LEN and the end of release, so no reset
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[idx[AW-1:0]] <= rx_data;
    end
  end

  // Next-state: consume popped bytes per state, decide frame outcome, step through release
  always_comb begin
    state_nx     = state;
    len_nx       = len;
    idx_nx       = idx;
    chk_nx       = chk;
    frame_ok_nx  = 1'b0;
    frame_err_nx = 1'b0;
    err_code_nx  = err_code;
    buf_we       = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_rd && (rx_data == SOF)) begin
          state_nx = S_LEN;
        end
      end

      S_LEN: begin
        if (rx_rd) begin
          if (len_good) begin
            len_nx   = LW'(rx_data);
            chk_nx   = rx_data;
            idx_nx   = '0;
            state_nx = S_PAYLOAD;
          end else begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_LEN;
            state_nx     = S_IDLE;
          end
        end else if (timeout) begin
          frame_err_nx = 1'b1;
          err_code_nx  = ERR_TO;
          state_nx     = S_IDLE;
        end
      end

      S_PAYLOAD: begin
        if (rx_rd) begin
          buf_we = 1'b1;
          chk_nx = chk ^ rx_data;
          idx_nx = idx + LW'(1);
          if (at_last) begin
            state_nx = S_CHK;
          end
        end else if (timeout) begin
          frame_err_nx = 1'b1;
          err_code_nx  = ERR_TO;
          state_nx     = S_IDLE;
        end
      end

      S_CHK: begin
        if (rx_rd) begin
          if (rx_data == chk) begin
            frame_ok_nx = 1'b1;
            idx_nx      = '0;
            state_nx    = S_OUT;
          end else begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_CHK;
            state_nx     = S_IDLE;
          end
        end else if (timeout) begin
          frame_err_nx = 1'b1;
          err_code_nx  = ERR_TO;
          state_nx     = S_IDLE;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          if (at_last) begin
            idx_nx   = '0;
            state_nx = S_IDLE;
          end else begin
            idx_nx = idx + LW'(1);
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: drives a modelled rx FIFO into uart_frame_parser and checks frames against a stream parser.
// Latency: checks first-byte timing, back-to-back release and timeout distance where enabled.
// Backpressure: random and forced out_ready stalls; output must hold and no bytes may be popped meanwhile.
module tb_uart_frame_parser;
  localparam int         DBIT    = 8;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         TB_TO   = 1024;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_empty;
  logic [DBIT-1:0] rx_data;
  logic            rx_rd;
  logic [DBIT-1:0] out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic            frame_ok;
  logic            frame_err;
  logic [1:0]      err_code;
  logic            busy;

  uart_frame_parser #(
    .DBIT(DBIT), .MAX_LEN(MAX_LEN), .SOF(SOF), .TIMEOUT_CYC(TB_TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  byte unsigned fifo_q[$];
  byte unsigned seg_stream[$];
  int exp_evt[$], obs_evt[$];   // 0 = frame_ok, otherwise err_code of the drop
  int exp_byte[$], obs_byte[$]; // bit 8 = last flag, bits 7:0 = data
  int obs_cyc[$];

  int cyc = 0, ok_cyc = 0, pop_cyc = 0, err_cyc = 0;
  bit pop_pend = 1'b0;
  bit bp_arm = 1'b0;
  int bp_left = 0;
  int gap_pct = 0;
  int rdy_pct = 100;
  bit prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // rx FIFO model and sink: present head after each edge, drop it once the DUT has popped it
  initial begin
    rx_empty  = 1'b1;
    rx_data   = '0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (fifo_q.size() == 0 || $urandom_range(99) < gap_pct) begin
        rx_empty = 1'b1;
        rx_data  = 8'($urandom);
      end else begin
        rx_empty = 1'b0;
        rx_data  = fifo_q[0];
      end
      if (bp_arm && frame_ok) begin
        bp_left = 5;
        bp_arm  = 1'b0;
      end
      if (bp_left > 0) begin
        out_ready = 1'b0;
        bp_left--;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  // Monitor: collect events and transfers, check cycle-level handshake rules
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      pop_pend   = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      pop_pend = rx_rd;
      if (rx_rd) pop_cyc = cyc;
      check_eq("rx_rd_rule", rx_rd, !rx_empty && !out_valid);
      if (!out_valid) check_eq("last_without_valid", out_last, 0);
      if (frame_ok || frame_err) check_eq("ok_err_exclusive", frame_ok && frame_err, 0);
      if (frame_ok) begin
        check_eq("valid_with_ok", out_valid, 1);
        obs_evt.push_back(0);
        ok_cyc = cyc;
      end
      if (frame_err) begin
        obs_evt.push_back(int'(err_code));
        err_cyc = cyc;
      end
      if (out_valid && !prev_valid) check_eq("ok_with_first_valid", frame_ok, 1);
      if (prev_valid && !prev_ready) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
        check_eq("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        obs_byte.push_back((out_last ? 256 : 0) + int'(out_data));
        obs_cyc.push_back(cyc);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_last  = out_last;
      prev_data  = out_data;
    end
  end

  // Reference: scan the byte stream frame by frame and list expected outcomes and payload bytes
  task automatic ref_parse();
    int i, n, len, x;
    i = 0;
    n = seg_stream.size();
    while (i < n) begin
      if (seg_stream[i] != SOF) begin
        i++;
      end else if (i + 1 >= n) begin
        i = n;
      end else begin
        len = seg_stream[i+1];
        i += 2;
        if (len < 1 || len > MAX_LEN) begin
          exp_evt.push_back(1);
        end else if (i + len >= n) begin
          i = n;
        end else begin
          x = len;
          for (int k = 0; k < len; k++) x ^= seg_stream[i+k];
          if (x == seg_stream[i+len]) begin
            exp_evt.push_back(0);
            for (int k = 0; k < len; k++)
              exp_byte.push_back(((k == len - 1) ? 256 : 0) + seg_stream[i+k]);
          end else begin
            exp_evt.push_back(2);
          end
          i += len + 1;
        end
      end
    end
  endtask

  task automatic feed1(input byte unsigned b);
    fifo_q.push_back(b);
    seg_stream.push_back(b);
  endtask

  task automatic feed(input byte unsigned bs[$]);
    foreach (bs[i]) feed1(bs[i]);
  endtask

  task automatic seg_begin();
    seg_stream.delete();
    exp_evt.delete();
    obs_evt.delete();
    exp_byte.delete();
    obs_byte.delete();
    obs_cyc.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_budget", n < 5000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic seg_end();
    drain();
    ref_parse();
    check_eq("evt_count", obs_evt.size(), exp_evt.size());
    foreach (exp_evt[i]) if (i < obs_evt.size()) check_eq("evt_kind", obs_evt[i], exp_evt[i]);
    check_eq("byte_count", obs_byte.size(), exp_byte.size());
    foreach (exp_byte[i]) if (i < obs_byte.size()) check_eq("byte_last_data", obs_byte[i], exp_byte[i]);
    check_eq("idle_after", busy, 0);
  endtask

  // Random frame item: 0 junk, 1 good, 2 bad checksum, 3 bad length
  task automatic add_item(input int kind);
    int len;
    byte unsigned b, x;
    case (kind)
      0: begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom);
          if (b == SOF) b = 8'h00;
          feed1(b);
        end
      end
      1, 2: begin
        len = $urandom_range(1, MAX_LEN);
        feed1(SOF);
        feed1(8'(len));
        x = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          feed1(b);
          x ^= b;
        end
        if (kind == 2) x ^= 8'($urandom_range(1, 255));
        feed1(x);
      end
      default: begin
        feed1(SOF);
        b = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
        feed1(b);
      end
    endcase
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_ok", frame_ok, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_rx_rd", rx_rd, 0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Good frame, back-to-back release
    gap_pct = 0; rdy_pct = 100;
    seg_begin();
    feed('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    seg_end();
    if (obs_cyc.size() == 3) begin
      check_eq("t1_first_at_ok", obs_cyc[0], ok_cyc);
      check_eq("t1_back_to_back", obs_cyc[2] - obs_cyc[0], 2);
    end

    // Bad checksum then a good frame; err_code holds across the good frame
    seg_begin();
    feed('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'hA5, 8'h01, 8'h55, 8'h54});
    seg_end();
    check_eq("t2_err_code_hold", err_code, 2);

    // Bad lengths (0 and MAX_LEN+1), following bytes hunted in IDLE
    seg_begin();
    feed('{8'hA5, 8'h00, 8'hA5, 8'h11, 8'h42, 8'hA5, 8'h01, 8'h07, 8'h06});
    seg_end();
    check_eq("t3_err_code_hold", err_code, 1);

    // Junk before SOF
    seg_begin();
    feed('{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h7E, 8'h7F});
    seg_end();

    // Backpressure for 5 cycles after frame_ok with a second frame queued
    seg_begin();
    bp_arm = 1'b1;
    feed('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'hA5, 8'h01, 8'h55, 8'h54});
    n = 0;
    while (!frame_ok && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_ok_seen", n < 200, 1);
    check_eq("t5_ready_low", out_ready, 0);
    check_eq("t5_hold_11", out_data, 8'h11);
    repeat (4) begin
      @(negedge clk);
      check_eq("t5_hold_11", out_data, 8'h11);
      check_eq("t5_no_pop", rx_rd, 0);
    end
    seg_end();

    // Reset mid-PAYLOAD, then a clean frame after release
    seg_begin();
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h04); fifo_q.push_back(8'h11);
    n = 0;
    while (fifo_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("t6_busy_in_payload", busy, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_out_valid", out_valid, 0);
    check_eq("t6_rst_out_last", out_last, 0);
    check_eq("t6_rst_frame_ok", frame_ok, 0);
    check_eq("t6_rst_frame_err", frame_err, 0);
    check_eq("t6_rst_err_code", err_code, 0);
    feed('{8'hA5, 8'h01, 8'h55, 8'h54});
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_rst_rx_rd", rx_rd, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_eq("t6_idle_after_release", busy, 0);
    seg_end();

`ifdef FRAME_TIMEOUT_EN
    // Stall mid-PAYLOAD until the inter-byte timeout fires
    seg_begin();
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h04); fifo_q.push_back(8'h11);
    n = 0;
    while (!frame_err && n < TB_TO + 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_err_seen", frame_err, 1);
    check_eq("to_err_code", err_code, 3);
    check_eq("to_distance", (err_cyc - pop_cyc >= TB_TO - 1) && (err_cyc - pop_cyc <= TB_TO + 2), 1);
    @(negedge clk);
    check_eq("to_idle", busy, 0);
`endif

    // Randomized streams with input gaps and output stalls
    for (int r = 0; r < 6; r++) begin
      seg_begin();
      gap_pct = $urandom_range(0, 60);
      rdy_pct = $urandom_range(30, 100);
      for (int k = 0; k < 8; k++) add_item($urandom_range(0, 3));
      seg_end();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Downstream consumer of the UART receive path. It pops bytes from the rx FIFO read port (empty/rd/r_data) and parses framed packets of the form SOF, LEN, payload, CHK. Each payload is buffered internally and released on a valid/ready stream only after the checksum passes. Errored frames are dropped and flagged.

Parameters:
DBIT, 8, byte width; must match the UART data width.
MAX_LEN, 16, maximum payload bytes per frame; sets the internal buffer depth.
SOF, 8'hA5, start-of-frame marker value.
TIMEOUT_CYC, 1024, inter-byte timeout in clk cycles; used only when FRAME_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-low reset.
rx_empty  in  1  rx FIFO empty flag.
rx_data  in  DBIT  rx FIFO head word; valid whenever rx_empty=0.
rx_rd  out  1  pop strobe to rx FIFO; the byte on rx_data is consumed in the same cycle.
out_data  out  DBIT  payload byte.
out_valid  out  1  out_data is valid.
out_last  out  1  marks the final payload byte of the frame.
out_ready  in  1  downstream accepts the byte when out_valid and out_ready are both 1.
frame_ok  out  1  one-cycle pulse: checksum passed, payload release starting.
frame_err  out  1  one-cycle pulse: frame dropped.
err_code  out  2  01 = bad length, 10 = bad checksum, 11 = timeout; holds its value until the next frame_err.
busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE; counters, checksum and err_code clear to 0.
  - frame_ok, frame_err, out_valid, out_last, busy are all 0.
  - rx_rd is forced to 0 while reset is asserted.
  - Reset mid-frame discards the partial frame. The buffer contents need not be cleared.
- Pop rule: rx_rd = ~rx_empty when state is IDLE, LEN, PAYLOAD or CHK; rx_rd = 0 in OUT. This means the FIFO absorbs backpressure during OUT.
- Per-state actions on a popped byte b:
  - IDLE: if b == SOF, go to LEN; otherwise discard b and stay in IDLE.
  - LEN: if 1 <= b <= MAX_LEN, latch len = b, set chk = b, clear idx, go to PAYLOAD. Otherwise pulse frame_err with err_code = 01 and go to IDLE.
  - PAYLOAD: write buf[idx] = b, set chk ^= b, increment idx. When idx reaches len-1 on this byte, go to CHK.
  - CHK: if b == chk, pulse frame_ok, clear idx, go to OUT. Otherwise pulse frame_err with err_code = 10 and go to IDLE.
  - OUT: out_valid = 1, out_data = buf[idx], out_last = (idx == len-1). On a transfer, increment idx. A transfer with out_last = 1 returns to IDLE.
- Timing and data-path rules:
  - frame_ok/frame_err are registered and assert in the cycle after the deciding byte is popped.
  - The first out_valid coincides with frame_ok. Latency from CHK pop to first out_valid is 1 cycle.
  - With out_ready held at 1, one byte transfers per cycle.
  - out_data, out_last and out_valid stay stable while out_valid=1 and out_ready=0.
  - Checksum is an XOR over LEN and all payload bytes, DBIT wide.
  - len and idx are $clog2(MAX_LEN+1) bits wide; no wrap-around is possible.
  - A SOF-valued byte inside LEN, PAYLOAD or CHK is treated as data; there is no resync.
- Simultaneous events:
  - rx_empty=0 during OUT has no effect.
  - frame_err and frame_ok never assert in the same cycle.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined: a cycle counter is active in LEN, PAYLOAD and CHK.
  - It clears on every pop and on every state entry.
  - When it reaches TIMEOUT_CYC with no pop, the block pulses frame_err with err_code = 11 and goes to IDLE.
  - The counter is idle in IDLE and OUT.
- Undefined: no counter logic exists; the block waits indefinitely for bytes, and err_code 11 is never produced.

Test Plan:
1. Good frame: feed A5 03 11 22 33 03, out_ready=1 -> frame_ok pulses once; out_data 11, 22, 33 on consecutive cycles; out_last only on 33; busy drops to 0 after.
2. Bad checksum: feed A5 02 10 20 00 (correct value is 32) -> frame_err pulses with err_code=10; out_valid never asserts; next frame A5 01 55 54 outputs 55.
3. Bad length: feed A5 00, then separately A5 11 (with MAX_LEN=16) -> frame_err with err_code=01 each time; the byte following each is hunted in IDLE.
4. Junk before SOF: feed 00 FF 3C A5 01 7E 7F -> the three junk bytes are popped and discarded; single output 7E with out_last=1.
5. Backpressure: good frame, out_ready=0 for 5 cycles after frame_ok with a following frame queued in the FIFO -> out_data holds 11; rx_rd stays 0 until the last byte transfers.
6. Timeout and reset (FRAME_TIMEOUT_EN defined): feed A5 04 11 then keep the FIFO empty for TIMEOUT_CYC cycles -> frame_err with err_code=11. Separately, pull reset low mid-PAYLOAD -> all outputs 0 immediately; IDLE after release.
